// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue stage and its request FIFO.
package alu_pkg;

  localparam int ALU_W  = 8;
  localparam int CTRL_W = 3;
  localparam int REQ_W  = 2 * ALU_W + CTRL_W;

  // Sequencer FSM: wait for work, drive the ALU for one cycle, hold the result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  // One queued operation: two operands and the ALU op select.
  typedef struct packed {
    logic [ALU_W-1:0]  data0;
    logic [ALU_W-1:0]  data1;
    logic [CTRL_W-1:0] ctrl;
  } alu_req_t;

  // Advance a wrap-bit FIFO pointer by one slot.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO. Wrap-bit pointers: full when the MSBs differ
// and the index bits match, empty when the pointers are identical.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  alu_req_t push_data_i,
  input  logic     pop_i,
  output alu_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  alu_req_t    r_mem [DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_wr_inc;
  logic [7:0]  w_rd_inc;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A full FIFO refuses pushes even when a pop happens on the same edge;
  // the freed slot becomes visible one cycle later.
  assign w_push  = push_i & ~w_full;
  assign w_pop   = pop_i & ~w_empty;

  assign w_wr_inc = ptr_inc(8'(r_wr_ptr));
  assign w_rd_inc = ptr_inc(8'(r_rd_ptr));

  assign head_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;

  // Pointer update; reset discards everything queued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_inc[AW:0];
      if (w_pop)  r_rd_ptr <= w_rd_inc[AW:0];
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of alu_top: queues requests, presents one at a time on
// registered ALU inputs, captures the combinational result a cycle later and
// returns it in order over a valid/ready response channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_data0_i,
  input  logic [7:0]       req_data1_i,
  input  logic [2:0]       req_ctrl_i,
  output logic [7:0]       alu_data0_o,
  output logic [7:0]       alu_data1_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [7:0]       alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [7:0]       rsp_result_o,
  output logic [2:0]       rsp_ctrl_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [7:0]       r_alu_data0;
  logic [7:0]       r_alu_data1;
  logic [2:0]       r_alu_ctrl;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_result;
  logic [2:0]       r_rsp_ctrl;
  logic [CNT_W-1:0] r_op_count;

  alu_req_t         w_push_req;
  alu_req_t         w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_rsp_hs;

  assign w_push_req = '{data0: req_data0_i, data1: req_data1_i, ctrl: req_ctrl_i};

  // RESP always has rsp_valid set, so ready in RESP is a handshake.
  assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready_i;

  // Fetch the next operation when idle, or back-to-back right after a handshake.
  assign w_pop = !w_empty && ((r_state == ST_IDLE) || w_rsp_hs);

  alu_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (req_valid_i),
    .push_data_i(w_push_req),
    .pop_i      (w_pop),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  // Next-state logic for the IDLE -> ISSUE -> RESP loop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready_i) w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ALU operand registers load only on a pop, so the ALU inputs never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alu_data0 <= '0;
      r_alu_data1 <= '0;
      r_alu_ctrl  <= '0;
    end else if (w_pop) begin
      r_alu_data0 <= w_head.data0;
      r_alu_data1 <= w_head.data1;
      r_alu_ctrl  <= w_head.ctrl;
    end
  end

  // Response registers: capture in ISSUE, hold through RESP until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_ctrl   <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_result_i;
      r_rsp_ctrl   <= r_alu_ctrl;
    end else if (w_rsp_hs) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Completed-operation counter, wraps silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_op_count <= '0;
    else if (w_rsp_hs) r_op_count <= r_op_count + CNT_W'(1);
  end

  assign req_ready_o  = ~w_full;
  assign alu_data0_o  = r_alu_data0;
  assign alu_data1_o  = r_alu_data1;
  assign alu_ctrl_o   = r_alu_ctrl;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_rsp_result;
  assign rsp_ctrl_o   = r_rsp_ctrl;
  assign busy_o       = !w_empty || (r_state != ST_IDLE);
  assign op_count_o   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural stand-in for alu_top.
// A queue-based model tracks accepted requests and checks every response.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_d0;
  logic [7:0]       req_d1;
  logic [2:0]       req_ctrl;
  logic [7:0]       alu_d0;
  logic [7:0]       alu_d1;
  logic [2:0]       alu_ctrl;
  logic [7:0]       alu_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [2:0]       rsp_ctrl;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // alu_top behaviour: combinational op on the two operands.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[6:0], 1'b0};
      3'd6:    return {1'b0, a[7:1]};
      default: return ~a;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_d0, alu_d1, alu_ctrl);

  alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data0_i (req_d0),
    .req_data1_i (req_d1),
    .req_ctrl_i  (req_ctrl),
    .alu_data0_o (alu_d0),
    .alu_data1_o (alu_d1),
    .alu_ctrl_o  (alu_ctrl),
    .alu_result_i(alu_res),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_ctrl_o  (rsp_ctrl),
    .busy_o      (busy),
    .op_count_o  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted requests in order, handshake count, last popped op.
  alu_req_t         m_q[$];
  alu_req_t         m_last;
  logic [CNT_W-1:0] m_cnt = '0;
  bit               m_hold = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      chk("rsp_without_req", 32'(rsp_valid && (m_q.size() == 0)), 0);
      if (m_hold) chk("valid_held", 32'(rsp_valid), 1);
      if (rsp_valid && m_q.size() != 0) begin
        chk("rsp_result", 32'(rsp_result), 32'(alu_fn(m_q[0].data0, m_q[0].data1, m_q[0].ctrl)));
        chk("rsp_ctrl", 32'(rsp_ctrl), 32'(m_q[0].ctrl));
        if (rsp_ready) begin
          chk("cnt_at_hs", 32'(op_count), 32'(m_cnt));
          m_last = m_q.pop_front();
          m_cnt++;
        end
      end
      m_hold = rsp_valid && !rsp_ready;
      if (req_valid && req_ready)
        m_q.push_back('{data0: req_d0, data1: req_d1, ctrl: req_ctrl});
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cnt  = '0;
    m_hold = 1'b0;
    m_last = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    model_clear();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    req_valid = 1'b1;
    req_d0 = a;
    req_d1 = b;
    req_ctrl = c;
  endtask

  task automatic drain();
    bit done = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      done = (m_q.size() == 0) && !busy;
    end
    chk("drain_done", 32'(done), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_d0 = '0;
    req_d1 = '0;
    req_ctrl = '0;
    model_clear();
    cyc();
    cyc();
    // Reset state
    chk("rst_alu_d0", 32'(alu_d0), 0);
    chk("rst_alu_d1", 32'(alu_d1), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    chk("rst_rsp_ctrl", 32'(rsp_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(op_count), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    cyc();

    // Single op: push at E0, response visible after E2
    drive_req(8'd6, 8'd2, 3'b000);
    rsp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("single_e0_valid", 32'(rsp_valid), 0);
    cyc();
    chk("single_e1_valid", 32'(rsp_valid), 0);
    chk("single_alu_d0", 32'(alu_d0), 6);
    chk("single_alu_d1", 32'(alu_d1), 2);
    cyc();
    chk("single_e2_valid", 32'(rsp_valid), 1);
    chk("single_result", 32'(rsp_result), 8);
    chk("single_ctrl", 32'(rsp_ctrl), 0);
    cyc();
    chk("single_cnt", 32'(op_count), 1);
    chk("single_idle", 32'(busy), 0);

    // Back-pressure: one op parked in RESP plus DEPTH queued fills the block
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(8'($urandom), 8'($urandom), 3'(i));
      cyc();
    end
    req_valid = 1'b0;
    chk("bp_full", 32'(req_ready), 0);
    repeat (3) cyc();
    chk("bp_hold_ctrl", 32'(rsp_ctrl), 0);
    chk("bp_hold_valid", 32'(rsp_valid), 1);

    // Push and response handshake on the same edge while full: push is dropped
    drive_req(8'hAA, 8'h55, 3'd7);
    rsp_ready = 1'b1;
    chk("full_pp_ready", 32'(req_ready), 0);
    cyc();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("full_pp_next_ready", 32'(req_ready), 1);
    drain();
    chk("bp_cnt", 32'(op_count), 6);

    // Reset mid-operation: ISSUE with three requests queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(8'($urandom), 8'($urandom), 3'(i));
      cyc();
    end
    drive_req(8'h11, 8'h22, 3'd4);
    rsp_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("mid_alu_d0", 32'(alu_d0), 0);
    chk("mid_alu_ctrl", 32'(alu_ctrl), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rsp_result", 32'(rsp_result), 0);
    chk("mid_busy_rst", 32'(busy), 0);
    chk("mid_cnt", 32'(op_count), 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("post_rst_valid", 32'(rsp_valid), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end

    // Randomized traffic with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) drive_req(8'($urandom), 8'($urandom), 3'($urandom));
      else req_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();
    chk("rand_cnt", 32'(op_count), 32'(m_cnt));

    // Counter wrap: 16 handshakes from reset bring the 4-bit count back to 0
    do_reset();
    begin
      int pushed = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 200 && pushed < 16; i++) begin
        drive_req(8'($urandom), 8'($urandom), 3'($urandom));
        if (req_ready) pushed++;
        cyc();
      end
      req_valid = 1'b0;
      chk("wrap_pushed", 32'(pushed), 16);
    end
    drain();
    chk("wrap_cnt", 32'(op_count), 0);

    // Idle stability: ALU inputs keep the last issued operation
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_alu_d0", 32'(alu_d0), 32'(m_last.data0));
      chk("idle_alu_d1", 32'(alu_d1), 32'(m_last.data1));
      chk("idle_alu_ctrl", 32'(alu_ctrl), 32'(m_last.ctrl));
      chk("idle_valid", 32'(rsp_valid), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
